// File: rtl/wrr_pkg.sv
// Shared constants and FSM encoding for the weighted round-robin packet scheduler.
package wrr_pkg;

  localparam int DEF_NUM_QUEUE    = 8;
  localparam int DEF_PRIORITY_BIT = 3;
  localparam int DEF_WEIGHT_BIT   = 4;

  // Weight and credit value every queue comes out of reset with
  localparam int RST_WEIGHT = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_GRANT = 2'd2
  } state_e;

endpackage

// File: rtl/wrr_sched_if.sv
// Scheduler bundle: weight config, queue status and output-side handshake in; grant out.
// master = scheduler side, slave = queue/output-port side.
interface wrr_sched_if import wrr_pkg::*; #(
  parameter int NUM_QUEUE    = DEF_NUM_QUEUE,
  parameter int PRIORITY_BIT = DEF_PRIORITY_BIT,
  parameter int WEIGHT_BIT   = DEF_WEIGHT_BIT
);

  logic                            cfg_vld;
  logic [NUM_QUEUE*WEIGHT_BIT-1:0] cfg_weight;
  logic [NUM_QUEUE-1:0]            q_nempty;
  logic                            out_rdy;
  logic                            pkt_done;
  logic [NUM_QUEUE-1:0]            grant;
  logic [PRIORITY_BIT-1:0]         grant_id;
  logic                            grant_vld;
  logic                            round_end;

  modport master (
    input  cfg_vld, cfg_weight, q_nempty, out_rdy, pkt_done,
    output grant, grant_id, grant_vld, round_end
  );

  modport slave (
    output cfg_vld, cfg_weight, q_nempty, out_rdy, pkt_done,
    input  grant, grant_id, grant_vld, round_end
  );

endinterface

// File: rtl/wrr_sched_rr_pick.sv
// Rotating priority encoder: first set req bit scanning from ptr upward, wrapping.
// Purely combinational; NUM_QUEUE must equal 2**PRIORITY_BIT so index arithmetic wraps.
module rr_pick import wrr_pkg::*; #(
  parameter int NUM_QUEUE    = DEF_NUM_QUEUE,
  parameter int PRIORITY_BIT = DEF_PRIORITY_BIT
) (
  input  logic [NUM_QUEUE-1:0]    req_i,
  input  logic [PRIORITY_BIT-1:0] ptr_i,
  output logic [PRIORITY_BIT-1:0] sel_o,
  output logic                    any_o
);

  // Scan from the farthest offset down so the nearest request is written last
  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    for (int k = NUM_QUEUE - 1; k >= 0; k--) begin
      if (req_i[ptr_i + PRIORITY_BIT'(k)]) begin
        sel_o = ptr_i + PRIORITY_BIT'(k);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_sched.sv
// Packet-granular WRR scheduler: one grant per packet, held until pkt_done; 2 cycles
// from non-empty to grant out of IDLE; out_rdy low in ARB stalls the grant, credits untouched.
module wrr_sched import wrr_pkg::*; #(
  parameter int NUM_QUEUE    = DEF_NUM_QUEUE,
  parameter int PRIORITY_BIT = DEF_PRIORITY_BIT,
  parameter int WEIGHT_BIT   = DEF_WEIGHT_BIT
) (
  input logic         clk,
  input logic         rst_n,
  wrr_sched_if.master bus
);

  typedef logic [NUM_QUEUE-1:0][WEIGHT_BIT-1:0] wvec_t;

  localparam wvec_t RST_VEC = {NUM_QUEUE{WEIGHT_BIT'(RST_WEIGHT)}};

  state_e                  state_q, state_d;
  logic [PRIORITY_BIT-1:0] ptr_q, ptr_d;
  wvec_t                   weight_act_q, weight_act_d;
  wvec_t                   weight_pend_q, weight_pend_d;
  wvec_t                   credit_q, credit_d;
  logic [NUM_QUEUE-1:0]    grant_q, grant_d;
  logic [PRIORITY_BIT-1:0] grant_id_q, grant_id_d;
  logic                    grant_vld_q, grant_vld_d;
  logic                    round_end_q, round_end_d;

  logic [NUM_QUEUE-1:0]    cand, elig;
  logic [PRIORITY_BIT-1:0] sel;
  logic                    any_elig;

  always_comb begin
    cand = '0;
    elig = '0;
    for (int i = 0; i < NUM_QUEUE; i++) begin
      cand[i] = bus.q_nempty[i] & (weight_act_q[i] != '0);
      elig[i] = cand[i] & (credit_q[i] != '0);
    end
  end

  rr_pick #(
    .NUM_QUEUE    (NUM_QUEUE),
    .PRIORITY_BIT (PRIORITY_BIT)
  ) u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .sel_o (sel),
    .any_o (any_elig)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    weight_act_d  = weight_act_q;
    weight_pend_d = bus.cfg_vld ? wvec_t'(bus.cfg_weight) : weight_pend_q;
    credit_d      = credit_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_vld_d   = grant_vld_q;
    round_end_d   = 1'b0;

    unique case (state_q)
      // Tracking pending weights while idle keeps a fully-disabled config from locking us out
      S_IDLE: begin
        weight_act_d = weight_pend_q;
        if (|cand) state_d = S_ARB;
      end
      S_ARB: begin
        if (!(|cand)) begin
          state_d      = S_IDLE;
          weight_act_d = weight_pend_q;
        end else if (!any_elig) begin
          credit_d     = weight_pend_q;
          weight_act_d = weight_pend_q;
          round_end_d  = 1'b1;
        end else if (bus.out_rdy) begin
          grant_d         = NUM_QUEUE'(1) << sel;
          grant_id_d      = sel;
          grant_vld_d     = 1'b1;
          credit_d[sel]   = credit_q[sel] - WEIGHT_BIT'(1);
          // Stay on a queue until its credit runs out, then move past it
          ptr_d           = (credit_q[sel] == WEIGHT_BIT'(1)) ? sel + PRIORITY_BIT'(1) : sel;
          state_d         = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.pkt_done) begin
          grant_d     = '0;
          grant_id_d  = '0;
          grant_vld_d = 1'b0;
          if (|cand) begin
            state_d = S_ARB;
          end else begin
            state_d      = S_IDLE;
            weight_act_d = weight_pend_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      weight_act_q  <= RST_VEC;
      weight_pend_q <= RST_VEC;
      credit_q      <= RST_VEC;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_vld_q   <= 1'b0;
      round_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      weight_act_q  <= weight_act_d;
      weight_pend_q <= weight_pend_d;
      credit_q      <= credit_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_vld_q   <= grant_vld_d;
      round_end_q   <= round_end_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.grant_vld = grant_vld_q;
  assign bus.round_end = round_end_q;

endmodule

// File: tb/tb_wrr_sched.sv
// Directed bench for wrr_sched: inputs change and outputs are sampled on the falling edge.
module tb_wrr_sched;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  wrr_sched_if #(.NUM_QUEUE(8), .PRIORITY_BIT(3), .WEIGHT_BIT(4)) bus ();

  wrr_sched #(.NUM_QUEUE(8), .PRIORITY_BIT(3), .WEIGHT_BIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input logic [7:0] nempty);
    rst_n          = 1'b0;
    bus.q_nempty   = nempty;
    bus.cfg_vld    = 1'b0;
    bus.cfg_weight = '0;
    bus.pkt_done   = 1'b0;
    bus.out_rdy    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Config applied with all queues empty so the FSM sits in IDLE and adopts it
  task automatic write_cfg(input logic [31:0] w);
    bus.cfg_vld    = 1'b1;
    bus.cfg_weight = w;
    @(negedge clk);
    bus.cfg_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Wait for one grant (counting round_end pulses on the way), then finish the packet
  task automatic serve(input logic [7:0] nempty_on_grant, input bit cfg_en,
                       input logic [31:0] cfg_w, output int id, output int re,
                       output logic [7:0] gnt, output bit tmo);
    re  = 0;
    tmo = 1'b1;
    id  = -1;
    gnt = '0;
    for (int c = 0; c < 50 && tmo; c++) begin
      if (bus.grant_vld) begin
        tmo = 1'b0;
      end else begin
        if (bus.round_end) re++;
        @(negedge clk);
      end
    end
    if (!tmo) begin
      id           = int'(bus.grant_id);
      gnt          = bus.grant;
      bus.q_nempty = nempty_on_grant;
      if (cfg_en) begin
        bus.cfg_vld    = 1'b1;
        bus.cfg_weight = cfg_w;
      end
      @(negedge clk);
      bus.cfg_vld = 1'b0;
      @(negedge clk);
      bus.pkt_done = 1'b1;
      @(negedge clk);
      bus.pkt_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.q_nempty   = 8'hFF;
    bus.cfg_vld    = 1'b0;
    bus.cfg_weight = '0;
    bus.pkt_done   = 1'b0;
    bus.out_rdy    = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.grant !== 8'h00) begin n_bad++; $display("FAIL rst_grant got=%h exp=00", bus.grant); end
    n_cmp++; if (bus.grant_vld !== 1'b0) begin n_bad++; $display("FAIL rst_grant_vld got=%b exp=0", bus.grant_vld); end
    n_cmp++; if (bus.grant_id !== 3'd0) begin n_bad++; $display("FAIL rst_grant_id got=%0d exp=0", bus.grant_id); end
    n_cmp++; if (bus.round_end !== 1'b0) begin n_bad++; $display("FAIL rst_round_end got=%b exp=0", bus.round_end); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.grant_vld !== 1'b0) begin n_bad++; $display("FAIL rst_lat_c1 got=%b exp=0", bus.grant_vld); end
    @(negedge clk);
    n_cmp++; if (bus.grant_vld !== 1'b1 || bus.grant_id !== 3'd0) begin
      n_bad++; $display("FAIL rst_lat_c2 vld=%b id=%0d exp vld=1 id=0", bus.grant_vld, bus.grant_id);
    end
  endtask

  task automatic test_weights();
    int id, re; logic [7:0] gnt, oh; bit tmo;
    int exp_id [10];
    int exp_re [10];
    exp_id = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    exp_re = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    apply_reset(8'h00);
    write_cfg(32'h0000_0013);
    bus.q_nempty = 8'h03;
    for (int i = 0; i < 10; i++) begin
      serve(8'h03, 1'b0, 32'h0, id, re, gnt, tmo);
      oh = 8'h01 << exp_id[i];
      n_cmp++; if (tmo || id != exp_id[i]) begin n_bad++; $display("FAIL wt_id[%0d] got=%0d exp=%0d tmo=%0b", i, id, exp_id[i], tmo); end
      n_cmp++; if (re != exp_re[i]) begin n_bad++; $display("FAIL wt_round_end[%0d] got=%0d exp=%0d", i, re, exp_re[i]); end
      n_cmp++; if (gnt !== oh) begin n_bad++; $display("FAIL wt_onehot[%0d] got=%h exp=%h", i, gnt, oh); end
    end
  endtask

  task automatic test_empty_refill();
    int id, re; logic [7:0] gnt; bit tmo;
    int          exp_id [9];
    int          exp_re [9];
    logic [7:0]  nxt [9];
    exp_id = '{2, 0, 2, 0, 0, 2, 2, 2, 0};
    exp_re = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    nxt    = '{8'h05, 8'h05, 8'h01, 8'h01, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05};
    apply_reset(8'h00);
    write_cfg(32'h0000_0402);
    bus.q_nempty = 8'h04;
    for (int i = 0; i < 9; i++) begin
      serve(nxt[i], 1'b0, 32'h0, id, re, gnt, tmo);
      n_cmp++; if (tmo || id != exp_id[i]) begin n_bad++; $display("FAIL refill_id[%0d] got=%0d exp=%0d tmo=%0b", i, id, exp_id[i], tmo); end
      n_cmp++; if (re != exp_re[i]) begin n_bad++; $display("FAIL refill_round_end[%0d] got=%0d exp=%0d", i, re, exp_re[i]); end
    end
  endtask

  task automatic test_zero_weight();
    int vld_hits, re_hits, id, re; logic [7:0] gnt; bit tmo;
    apply_reset(8'h00);
    write_cfg(32'h0000_0000);
    bus.q_nempty = 8'hFF;
    vld_hits = 0;
    re_hits  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.grant_vld) vld_hits++;
      if (bus.round_end) re_hits++;
    end
    n_cmp++; if (vld_hits != 0) begin n_bad++; $display("FAIL zero_wt_grant got=%0d cycles exp=0", vld_hits); end
    n_cmp++; if (re_hits != 0) begin n_bad++; $display("FAIL zero_wt_round_end got=%0d pulses exp=0", re_hits); end
    write_cfg(32'h1111_1111);
    serve(8'hFF, 1'b0, 32'h0, id, re, gnt, tmo);
    n_cmp++; if (tmo || id != 0 || re != 0) begin
      n_bad++; $display("FAIL zero_wt_recover got id=%0d re=%0d tmo=%0b exp id=0 re=0", id, re, tmo);
    end
  endtask

  task automatic test_cfg_midround();
    int id, re; logic [7:0] gnt; bit tmo;
    int exp_id [10];
    int exp_re [10];
    exp_id = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 1};
    exp_re = '{0, 0, 1, 0, 0, 0, 1, 0, 1, 0};
    apply_reset(8'h00);
    write_cfg(32'h0000_0013);
    bus.q_nempty = 8'h03;
    for (int i = 0; i < 10; i++) begin
      serve(8'h03, (i == 2), 32'h0000_0011, id, re, gnt, tmo);
      n_cmp++; if (tmo || id != exp_id[i]) begin n_bad++; $display("FAIL cfg_id[%0d] got=%0d exp=%0d tmo=%0b", i, id, exp_id[i], tmo); end
      n_cmp++; if (re != exp_re[i]) begin n_bad++; $display("FAIL cfg_round_end[%0d] got=%0d exp=%0d", i, re, exp_re[i]); end
    end
  endtask

  task automatic test_backpressure_reset();
    int vld_hits, re_hits, id, re; logic [7:0] gnt; bit tmo, seen;
    int exp_id [3];
    int exp_re [3];
    exp_id = '{0, 1, 0};
    exp_re = '{0, 0, 1};
    apply_reset(8'h01);
    bus.out_rdy = 1'b0;
    vld_hits = 0;
    re_hits  = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.grant_vld) vld_hits++;
      if (bus.round_end) re_hits++;
    end
    n_cmp++; if (vld_hits != 0) begin n_bad++; $display("FAIL bp_stall_grant got=%0d cycles exp=0", vld_hits); end
    n_cmp++; if (re_hits != 0) begin n_bad++; $display("FAIL bp_stall_round_end got=%0d pulses exp=0", re_hits); end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.grant_vld !== 1'b1 || bus.grant !== 8'h01) begin
      n_bad++; $display("FAIL bp_release got vld=%b grant=%h exp vld=1 grant=01", bus.grant_vld, bus.grant);
    end
    @(negedge clk);
    bus.pkt_done = 1'b1;
    @(negedge clk);
    bus.pkt_done = 1'b0;
    // q0 had exactly one credit, so its next packet needs a reload first
    serve(8'h01, 1'b0, 32'h0, id, re, gnt, tmo);
    n_cmp++; if (tmo || id != 0 || re != 1) begin
      n_bad++; $display("FAIL bp_credit got id=%0d re=%0d tmo=%0b exp id=0 re=1", id, re, tmo);
    end
    bus.q_nempty = 8'h03;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (bus.grant_vld) seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rst_mid_setup got no grant exp grant_vld=1"); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.grant_vld !== 1'b0 || bus.grant !== 8'h00) begin
      n_bad++; $display("FAIL rst_mid_grant got vld=%b grant=%h exp vld=0 grant=00", bus.grant_vld, bus.grant);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      serve(8'h03, 1'b0, 32'h0, id, re, gnt, tmo);
      n_cmp++; if (tmo || id != exp_id[i] || re != exp_re[i]) begin
        n_bad++; $display("FAIL rst_mid_after[%0d] got id=%0d re=%0d tmo=%0b exp id=%0d re=%0d", i, id, re, tmo, exp_id[i], exp_re[i]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_weights();
    test_empty_refill();
    test_zero_weight();
    test_cfg_midround();
    test_backpressure_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
